// File: rtl/tick_pkg.sv
// Shared types for the cascaded tick generator: FSM states and decade counter type.
package tick_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StPause,
      StDone
   } state_e;

   typedef logic [3:0] dec_cnt_t;

   localparam dec_cnt_t DEC_MAX = 4'd9;

endpackage

// File: rtl/decade_cnt.sv
// One decade stage: counts 0..9 on each enable; passes the enable on as it wraps.
module decade_cnt
   import tick_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     en_in,
   input  logic     clr,
   output logic     en_out,
   output dec_cnt_t cnt
);

   dec_cnt_t cnt_q;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt_q <= '0;
      end else if (en_in) begin
         cnt_q <= (cnt_q == DEC_MAX) ? '0 : cnt_q + 4'd1;
      end
   end

   // Combinational carry so coincident ticks of all stages land on the same clock.
   assign en_out = en_in && (cnt_q == DEC_MAX);
   assign cnt    = cnt_q;

endmodule

// File: rtl/tick_gen_cascade.sv
// Base tick divider with run/pause/clear FSM, loadable divisor, one-shot mode and a
// chain of decade ticks below the base rate.
module tick_gen_cascade
   import tick_pkg::*;
#(
   parameter int unsigned DIV_W   = 24,
   parameter int unsigned DEF_DIV = 1_000_000,
   parameter int unsigned N_CH    = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             clear,
   input  logic             oneshot,
   input  logic             div_load,
   input  logic [DIV_W-1:0] div_value,
   output logic [N_CH-1:0]  tick,
   output logic             busy,
   output logic             done
);

   localparam logic [DIV_W-1:0] DefDiv = DIV_W'(DEF_DIV);
   localparam logic [DIV_W-1:0] One    = DIV_W'(1);

   state_e           state_q, state_d;
   logic [DIV_W-1:0] base_cnt_q;
   logic [DIV_W-1:0] div_act_q, div_shd_q;
   logic             mode_q;
   logic [N_CH-1:0]  tick_q;
   logic             busy_q, done_q;

   logic [N_CH-1:0]  fire;
   logic [N_CH-1:0]  dec_nz;
   logic             count_en;
   logic             base_wrap;
   logic [DIV_W-1:0] div_cap;

   assign div_cap   = (div_value == '0) ? One : div_value;
   // A pause request on the wrap cycle wins: the wrap is deferred until resume.
   assign count_en  = (state_q == StRun) && run && !clear;
   assign base_wrap = count_en && (base_cnt_q == div_act_q - One);
   assign fire[0]   = base_wrap;
   assign dec_nz[0] = (base_cnt_q != '0);

   for (genvar k = 1; k < N_CH; k++) begin : g_dec
      dec_cnt_t cnt;

      decade_cnt u_dec (
         .clk    (clk),
         .reset  (reset),
         .en_in  (fire[k-1]),
         .clr    (clear),
         .en_out (fire[k]),
         .cnt    (cnt)
      );

      assign dec_nz[k] = (cnt != '0);
   end

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle:  if (run) state_d = StRun;
            StRun: begin
               if (!run) begin
                  state_d = StPause;
               end else if (mode_q && fire[N_CH-1]) begin
                  state_d = StDone;
               end
            end
            StPause: if (run) state_d = StRun;
            StDone:  state_d = StDone;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         base_cnt_q <= '0;
         div_act_q  <= DefDiv;
         div_shd_q  <= DefDiv;
         mode_q     <= 1'b0;
         tick_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == StRun);
         done_q  <= (state_d == StDone);
         tick_q  <= fire;

         if (state_q == StIdle && state_d == StRun) begin
            mode_q <= oneshot;
         end

         if (clear || base_wrap) begin
            base_cnt_q <= '0;
         end else if (count_en) begin
            base_cnt_q <= base_cnt_q + One;
         end else if (div_load && state_q == StPause) begin
            base_cnt_q <= '0;
         end

         // While running, a new divisor waits in the shadow until the period boundary.
         if (div_load) begin
            div_shd_q <= div_cap;
            if (state_q != StRun || base_wrap) begin
               div_act_q <= div_cap;
            end
         end else if (base_wrap) begin
            div_act_q <= div_shd_q;
         end
      end
   end

   // Counters are parked at zero whenever the FSM is idle or finished.
   parked_at_zero: assert property (@(posedge clk) disable iff (reset)
      (state_q inside {StRun, StPause}) || (dec_nz == '0));

   assign tick = tick_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_tick_gen_cascade.sv
// Scoreboard bench for tick_gen_cascade with DEF_DIV=4, N_CH=3: directed stimulus pushes
// expected ticks with their cycle stamps; a monitor pops and compares every observed tick.
module tb_tick_gen_cascade;

   localparam int unsigned DIV_W = 8;
   localparam int unsigned N_CH  = 3;

   logic             clk       = 1'b0;
   logic             reset     = 1'b1;
   logic             run       = 1'b0;
   logic             clear     = 1'b0;
   logic             oneshot   = 1'b0;
   logic             div_load  = 1'b0;
   logic [DIV_W-1:0] div_value = '0;
   logic [N_CH-1:0]  tick;
   logic             busy;
   logic             done;

   int cyc   = 0;
   int total = 0;
   int bad   = 0;

   typedef struct {
      int              cyc;
      logic [N_CH-1:0] tick;
   } exp_t;

   exp_t sb_q[$];

   tick_gen_cascade #(
      .DIV_W   (DIV_W),
      .DEF_DIV (4),
      .N_CH    (N_CH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .run       (run),
      .clear     (clear),
      .oneshot   (oneshot),
      .div_load  (div_load),
      .div_value (div_value),
      .tick      (tick),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every non-zero tick must match the head of the scoreboard.
   always @(negedge clk) begin
      if (tick !== '0) begin
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL tick_unexpected at cyc %0d: got tick=%b, required none", cyc, tick);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.cyc != cyc || e.tick !== tick) begin
               bad++;
               $display("FAIL tick_seq: got tick=%b at cyc %0d, required tick=%b at cyc %0d",
                        tick, cyc, e.tick, e.cyc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout at cyc %0d", cyc);
      $fatal(1, "timeout");
   end

   task automatic push(input int c, input logic [N_CH-1:0] t);
      exp_t e;
      e.cyc  = c;
      e.tick = t;
      sb_q.push_back(e);
   endtask

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s at cyc %0d: got %0d, required %0d", name, cyc, act, req);
      end
   endtask

   task automatic goto(input int k);
      while (cyc < k) @(negedge clk);
   endtask

   task automatic load_div(input logic [DIV_W-1:0] v);
      div_value = v;
      div_load  = 1'b1;
      @(negedge clk);
      div_load  = 1'b0;
   endtask

   initial begin
      int c;
      logic [N_CH-1:0] t;

      repeat (2) @(negedge clk);
      check("reset_tick", int'(tick), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      reset = 1'b0;
      @(negedge clk);

      // 1: free run with the default divisor, decade ticks aligned.
      c   = cyc;
      run = 1'b1;
      for (int m = 1; m <= 105; m++) begin
         t = {(m % 100 == 0), (m % 10 == 0), 1'b1};
         push(c + 1 + 4 * m, t);
      end
      goto(c + 10);
      check("t1_busy", int'(busy), 1);
      check("t1_done", int'(done), 0);
      goto(c + 423);
      run   = 1'b0;
      clear = 1'b1;
      goto(c + 424);
      clear = 1'b0;
      check("t1_drain", sb_q.size(), 0);
      check("t1_clear_busy", int'(busy), 0);

      // 2: pause holds the count; next tick after 12 counting cycles in total.
      c   = cyc;
      run = 1'b1;
      push(c + 5, 3'b001);
      push(c + 9, 3'b001);
      push(c + 21, 3'b001);
      goto(c + 11);
      run = 1'b0;
      goto(c + 15);
      check("t2_pause_busy", int'(busy), 0);
      goto(c + 18);
      run = 1'b1;
      goto(c + 20);
      check("t2_resume_busy", int'(busy), 1);
      goto(c + 22);
      run   = 1'b0;
      clear = 1'b1;
      goto(c + 23);
      clear = 1'b0;
      goto(c + 24);
      check("t2_drain", sb_q.size(), 0);

      // 3: divisor loads while running take effect at the next wrap; zero acts as one.
      c   = cyc;
      run = 1'b1;
      push(c + 5, 3'b001);
      push(c + 9, 3'b001);
      push(c + 13, 3'b001);
      push(c + 15, 3'b001);
      push(c + 17, 3'b001);
      push(c + 19, 3'b001);
      push(c + 21, 3'b001);
      push(c + 23, 3'b001);
      push(c + 24, 3'b001);
      push(c + 25, 3'b011);
      push(c + 26, 3'b001);
      push(c + 27, 3'b001);
      goto(c + 10);
      load_div(8'd2);
      goto(c + 21);
      load_div(8'd0);
      goto(c + 27);
      clear = 1'b1;
      run   = 1'b0;
      goto(c + 28);
      clear = 1'b0;
      goto(c + 29);
      check("t3_drain", sb_q.size(), 0);

      // 4: one-shot ends on the first ch2 tick; mode latched at start, run ignored in DONE.
      load_div(8'd4);
      c       = cyc;
      oneshot = 1'b1;
      run     = 1'b1;
      for (int m = 1; m <= 100; m++) begin
         t = {(m % 100 == 0), (m % 10 == 0), 1'b1};
         push(c + 1 + 4 * m, t);
      end
      goto(c + 5);
      oneshot = 1'b0;
      goto(c + 200);
      check("t4_mid_busy", int'(busy), 1);
      check("t4_mid_done", int'(done), 0);
      goto(c + 401);
      check("t4_done", int'(done), 1);
      check("t4_busy", int'(busy), 0);
      goto(c + 405);
      run = 1'b0;
      goto(c + 410);
      run = 1'b1;
      goto(c + 430);
      check("t4_done_held", int'(done), 1);
      check("t4_busy_held", int'(busy), 0);
      check("t4_drain", sb_q.size(), 0);
      clear = 1'b1;
      run   = 1'b0;
      goto(c + 431);
      clear = 1'b0;
      check("t4_clear_done", int'(done), 0);

      // 5: clear beats run mid-count; restart gives a full first period.
      c   = cyc;
      run = 1'b1;
      push(c + 5, 3'b001);
      push(c + 13, 3'b001);
      goto(c + 7);
      clear = 1'b1;
      goto(c + 8);
      check("t5_clear_busy", int'(busy), 0);
      clear = 1'b0;
      goto(c + 14);
      run   = 1'b0;
      clear = 1'b1;
      goto(c + 15);
      clear = 1'b0;
      goto(c + 16);
      check("t5_drain", sb_q.size(), 0);

      // 6: reset mid-run clears outputs and restores the default divisor.
      load_div(8'd2);
      c   = cyc;
      run = 1'b1;
      push(c + 3, 3'b001);
      push(c + 5, 3'b001);
      goto(c + 6);
      reset = 1'b1;
      run   = 1'b0;
      goto(c + 7);
      check("t6_reset_tick", int'(tick), 0);
      check("t6_reset_busy", int'(busy), 0);
      check("t6_reset_done", int'(done), 0);
      reset = 1'b0;
      goto(c + 8);
      c   = cyc;
      run = 1'b1;
      push(c + 5, 3'b001);
      push(c + 9, 3'b001);
      goto(c + 10);
      run   = 1'b0;
      clear = 1'b1;
      goto(c + 11);
      clear = 1'b0;
      goto(c + 12);
      check("final_drain", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
